// File: rtl/seg_pkg.sv
// Shared glyph constants, snapshot layout and leading-zero helper for the
// multiplexed seven-segment scanner.
package seg_pkg;

  // Glyphs are active-low, bit 6 = segment a down to bit 0 = segment g.
  localparam logic [6:0] SEG_0    = 7'b000_0001;
  localparam logic [6:0] SEG_1    = 7'b100_1111;
  localparam logic [6:0] SEG_2    = 7'b001_0010;
  localparam logic [6:0] SEG_3    = 7'b000_0110;
  localparam logic [6:0] SEG_4    = 7'b100_1100;
  localparam logic [6:0] SEG_5    = 7'b010_0100;
  localparam logic [6:0] SEG_6    = 7'b010_0000;
  localparam logic [6:0] SEG_7    = 7'b000_1111;
  localparam logic [6:0] SEG_8    = 7'b000_0000;
  localparam logic [6:0] SEG_9    = 7'b000_0100;
  localparam logic [6:0] SEG_DASH = 7'b111_1110;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam int CLK_DIV_DEFAULT = 100000;
  localparam int CNT_W           = 20;

  typedef struct packed {
    logic [3:0][3:0] digits;
    logic [3:0]      dp;
    logic            blank;
  } snapshot_t;

  // Bit i set means digit i is a suppressed leading zero; digit 0 always shows.
  function automatic logic [3:0] leadBlankMask(input logic [3:0][3:0] digits,
                                               input logic            blank);
    logic [3:0] mask;
    mask = '0;
    if (blank) begin
      mask[3] = (digits[3] == 4'd0);
      mask[2] = mask[3] && (digits[2] == 4'd0);
      mask[1] = mask[2] && (digits[1] == 4'd0);
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_to_segment.sv
// Combinational BCD to active-low seven-segment glyph; non-decimal codes
// render as a dash.
module bcd_to_segment
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Four-digit multiplexed seven-segment driver: prescaled slot scan, per-frame
// input snapshot, leading-zero blanking and registered anode/segment outputs.
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_en,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [7:0] segs
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  snapshot_t        r_snap;
  logic [3:0]       r_an;
  logic [7:0]       r_segs;

  logic             w_tick;
  logic             w_frameEnd;
  snapshot_t        w_snapIn;
  logic [3:0]       w_blankMask;
  logic [3:0]       w_selDigit;
  logic [6:0]       w_glyph;
  logic [3:0]       w_nextAn;
  logic [7:0]       w_nextSegs;

  assign w_tick     = (r_cnt == CNT_MAX);
  assign w_frameEnd = w_tick && (r_idx == 2'd3);

  assign w_snapIn.digits = {digit3, digit2, digit1, digit0};
  assign w_snapIn.dp     = dp_en;
  assign w_snapIn.blank  = blank_lead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Inputs are only sampled at the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (w_frameEnd) begin
      r_snap <= w_snapIn;
    end
  end

  assign w_blankMask = leadBlankMask(r_snap.digits, r_snap.blank);
  assign w_selDigit  = r_snap.digits[r_idx];

  bcd_to_segment u_decode (
    .i_bcd (w_selDigit),
    .o_seg (w_glyph)
  );

  always_comb begin
    w_nextAn   = AN_OFF;
    w_nextSegs = SEG_OFF;
    if (!w_blankMask[r_idx]) begin
      w_nextAn[r_idx] = 1'b0;
      w_nextSegs      = {w_glyph, ~r_snap.dp[r_idx]};
    end
  end

  // Registering the drives keeps anode changes glitch-free between slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an   <= AN_OFF;
      r_segs <= SEG_OFF;
    end else begin
      r_an   <= w_nextAn;
      r_segs <= w_nextSegs;
    end
  end

  assign an   = r_an;
  assign segs = r_segs;

endmodule
